tx_eth_header_builder: RTL

Per-packet Ethernet framing stage that sits directly upstream of the endpoint MAC lookup block and consumes its results. It accepts a TX request carrying the destination IP and fires one lookup per packet. On a hit it emits the 14-byte Ethernet header built from the returned MACs, then passes the packet payload byte stream through unchanged. On a miss, error or timeout it discards the payload and counts the drop.

---
 rtl/tx_eth_header_builder_if.sv | 60 ++++++
 rtl/tx_eth_header_builder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tx_eth_header_builder_if.sv
// Port bundle of the TX Ethernet header builder: request, lookup, payload in, framed out.
// The master modport is the builder's own view; slave is the surrounding environment.
interface tx_eth_header_builder_if #(
  parameter int unsigned CNT_W = 16
);
  // Packet request
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_dst_ip;

  // Endpoint MAC lookup request and result
  logic              lookup_valid;
  logic              lookup_ready;
  logic [31:0]       dst_ip;
  logic              lookup_done;
  logic              lookup_hit;
  logic              lookup_error;
  logic [47:0]       dst_mac;
  logic [47:0]       src_mac;

  // Payload byte stream in
  logic [7:0]        s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;

  // Framed byte stream out
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;

  // Status
  logic [CNT_W-1:0]  drop_count;
  logic              busy;

  modport master (
    input  req_valid, req_dst_ip,
    output req_ready,
    output lookup_valid, dst_ip,
    input  lookup_ready, lookup_done, lookup_hit, lookup_error, dst_mac, src_mac,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready,
    output drop_count, busy
  );

  modport slave (
    output req_valid, req_dst_ip,
    input  req_ready,
    input  lookup_valid, dst_ip,
    output lookup_ready, lookup_done, lookup_hit, lookup_error, dst_mac, src_mac,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready,
    input  drop_count, busy
  );
endinterface

// File: rtl/tx_eth_header_builder.sv
// Per-packet Ethernet framing: one MAC lookup per request, then a 14-byte header and
// payload passthrough on a hit, or a payload drain plus drop count on miss/error/timeout.
module tx_eth_header_builder #(
  parameter logic [15:0] ETHERTYPE      = 16'h0800,
  parameter int unsigned LOOKUP_TIMEOUT = 256,
  parameter int unsigned CNT_W          = 16
) (
  input logic                     clk,
  input logic                     rstn,
  tx_eth_header_builder_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_HDR     = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_DROP    = 3'd5;

  localparam int unsigned         TMR_W    = $clog2(LOOKUP_TIMEOUT);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(LOOKUP_TIMEOUT - 1);
  localparam logic [3:0]          HDR_LAST = 4'd13;

  logic [2:0]        state, state_d;
  logic [TMR_W-1:0]  timer;
  logic [3:0]        hdr_idx;
  logic [47:0]       dst_mac_q;
  logic [47:0]       src_mac_q;
  logic [31:0]       dst_ip_q;
  logic              req_ready_q;
  logic [CNT_W-1:0]  drop_cnt;

  logic              lookup_ok;
  logic [7:0]        hdr_byte;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              s_tready;

  assign lookup_ok = bus.lookup_done && bus.lookup_hit && !bus.lookup_error;

  // Header byte selection: destination MAC, source MAC, EtherType, all MSB first.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      4'd0:    hdr_byte = dst_mac_q[47:40];
      4'd1:    hdr_byte = dst_mac_q[39:32];
      4'd2:    hdr_byte = dst_mac_q[31:24];
      4'd3:    hdr_byte = dst_mac_q[23:16];
      4'd4:    hdr_byte = dst_mac_q[15:8];
      4'd5:    hdr_byte = dst_mac_q[7:0];
      4'd6:    hdr_byte = src_mac_q[47:40];
      4'd7:    hdr_byte = src_mac_q[39:32];
      4'd8:    hdr_byte = src_mac_q[31:24];
      4'd9:    hdr_byte = src_mac_q[23:16];
      4'd10:   hdr_byte = src_mac_q[15:8];
      4'd11:   hdr_byte = src_mac_q[7:0];
      4'd12:   hdr_byte = ETHERTYPE[15:8];
      4'd13:   hdr_byte = ETHERTYPE[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Stream outputs are a pure decode of state, so an async reset zeroes them at once.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    m_tdata  = 8'h00;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = 1'b0;
    case (state)
      S_HDR: begin
        m_tdata  = hdr_byte;
        m_tvalid = 1'b1;
      end
      S_PAYLOAD: begin
        m_tdata  = bus.s_axis_tdata;
        m_tvalid = bus.s_axis_tvalid;
        m_tlast  = bus.s_axis_tlast;
        s_tready = bus.m_axis_tready;
      end
      S_DROP:  s_tready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (bus.req_valid && req_ready_q) state_d = S_LOOKUP;
      S_LOOKUP:  if (bus.lookup_ready) state_d = S_WAIT;
      S_WAIT: begin
        // A result arriving on the last timeout cycle still takes precedence.
        if (bus.lookup_done)      state_d = lookup_ok ? S_HDR : S_DROP;
        else if (timer == TMR_LAST) state_d = S_DROP;
      end
      S_HDR:     if (bus.m_axis_tready && hdr_idx == HDR_LAST) state_d = S_PAYLOAD;
      S_PAYLOAD: if (bus.s_axis_tvalid && bus.m_axis_tready && bus.s_axis_tlast) state_d = S_IDLE;
      S_DROP:    if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      timer       <= '0;
      hdr_idx     <= '0;
      dst_mac_q   <= '0;
      src_mac_q   <= '0;
      dst_ip_q    <= '0;
      req_ready_q <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_d;
      req_ready_q <= (state_d == S_IDLE);
      case (state)
        S_IDLE:
          if (bus.req_valid && req_ready_q) dst_ip_q <= bus.req_dst_ip;
        S_LOOKUP:
          if (bus.lookup_ready) timer <= '0;
        S_WAIT: begin
          timer <= timer + TMR_W'(1);
          if (lookup_ok) begin
            dst_mac_q <= bus.dst_mac;
            src_mac_q <= bus.src_mac;
            hdr_idx   <= '0;
          end
        end
        S_HDR:
          if (bus.m_axis_tready) hdr_idx <= (hdr_idx == HDR_LAST) ? 4'd0 : hdr_idx + 4'd1;
        S_DROP:
          if (bus.s_axis_tvalid && bus.s_axis_tlast && drop_cnt != '1)
            drop_cnt <= drop_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.lookup_valid  = (state == S_LOOKUP);
  assign bus.dst_ip        = dst_ip_q;
  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tdata  = m_tdata;
  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.m_axis_tlast  = m_tlast;
  assign bus.drop_count    = drop_cnt;
  assign bus.busy          = (state != S_IDLE);

endmodule
